// File: rtl/dmem_timer_pkg.sv
// Shared definitions for the data-memory-mapped machine timer:
// access-size encodings, register offsets, ctrl bit layout and a byte-merge helper.
package dmem_timer_pkg;

  // RW_type[1:0] access sizes (RISC-V funct3 low bits); RW_type[2] selects zero-extension
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam int         ZEXT_BIT = 2;

  // Word index inside the 32-byte window (addr[4:2])
  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;

  localparam int          CTRL_EN_BIT    = 0;
  localparam int          CTRL_IE_BIT    = 1;
  localparam int          CTRL_PRESC_LSB = 8;
  localparam int          PRESC_W        = 8;
  localparam logic [31:0] CTRL_MASK      = 32'h0000_FF03;

  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Decoded store lanes: which bytes change and the lane-replicated data
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } lane_wr_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_timer_prescaler.sv
// Prescaler for the machine timer: produces one tick every PRESC+1 enabled cycles.
module dmem_timer_prescaler
  import dmem_timer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clear,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;

  assign tick = en && (presc_cnt == presc);

  // clear wins over counting so a ctrl store always restarts the period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (clear) begin
      presc_cnt <= '0;
    end else if (en) begin
      if (presc_cnt == presc) presc_cnt <= '0;
      else                    presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_timer.sv
// Machine timer responder on the single-cycle core's data-memory port:
// 64-bit mtime with prescaler, 64-bit mtimecmp, ctrl register, registered interrupt.
module dmem_timer
  import dmem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        W_en,
  input  logic        R_en,
  input  logic [31:0] addr,
  input  logic [2:0]  RW_type,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        hit,
  output logic        timer_irq
);

  // Access semantics: there is no handshake. A load (R_en & hit) returns data
  // combinationally in the same cycle from pre-edge state; a store (W_en & hit)
  // commits on the rising edge. Both may occur in one cycle.

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] mtimeh_shadow;
  logic [31:0] ctrl;

  logic [2:0]  reg_idx;
  logic [1:0]  lane;
  logic [1:0]  size;
  logic        aligned;
  lane_wr_t    lane_wr;
  logic [3:0]  wr_be;
  logic        wr_any;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic        snap;
  logic        tick;
  logic [31:0] rd_word;
  logic [31:0] rd_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign reg_idx = addr[4:2];
  assign lane    = addr[1:0];
  assign size    = RW_type[1:0];
  assign hit     = (addr[31:5] == BASE_ADDR[31:5]);

  // Lane decode shared by loads and stores
  always_comb begin
    aligned      = 1'b0;
    lane_wr.be   = 4'b0000;
    lane_wr.data = din;
    case (size)
      SIZE_B: begin
        aligned      = 1'b1;
        lane_wr.be   = 4'b0001 << lane;
        lane_wr.data = {4{din[7:0]}};
      end
      SIZE_H: begin
        aligned      = ~lane[0];
        lane_wr.be   = lane[1] ? 4'b1100 : 4'b0011;
        lane_wr.data = {2{din[15:0]}};
      end
      SIZE_W: begin
        aligned      = (lane == 2'b00);
        lane_wr.be   = 4'b1111;
        lane_wr.data = din;
      end
      default: begin
        aligned      = 1'b0;
        lane_wr.be   = 4'b0000;
        lane_wr.data = din;
      end
    endcase
  end

  assign wr_be       = (W_en && hit && aligned) ? lane_wr.be : 4'b0000;
  assign wr_any      = |wr_be;
  assign wr_mtime_lo = wr_any && (reg_idx == IDX_MTIME_LO);
  assign wr_mtime_hi = wr_any && (reg_idx == IDX_MTIME_HI);
  assign wr_cmp_lo   = wr_any && (reg_idx == IDX_CMP_LO);
  assign wr_cmp_hi   = wr_any && (reg_idx == IDX_CMP_HI);
  assign wr_ctrl     = wr_any && (reg_idx == IDX_CTRL);

  // Any load touching the low mtime word freezes the high word for a later read
  assign snap = R_en && hit && (reg_idx == IDX_MTIME_LO);

  dmem_timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl[CTRL_EN_BIT]),
    .presc (ctrl[CTRL_PRESC_LSB +: PRESC_W]),
    .clear (wr_ctrl),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime         <= '0;
      mtimeh_shadow <= '0;
      mtimecmp      <= CMP_RESET;
      ctrl          <= '0;
      timer_irq     <= 1'b0;
    end else begin
      // A store to either mtime word suppresses this cycle's tick
      if (wr_mtime_lo || wr_mtime_hi) begin
        if (wr_mtime_lo) mtime[31:0]  <= merge_bytes(mtime[31:0], lane_wr.data, wr_be);
        if (wr_mtime_hi) mtime[63:32] <= merge_bytes(mtime[63:32], lane_wr.data, wr_be);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr_mtime_hi)  mtimeh_shadow <= merge_bytes(mtime[63:32], lane_wr.data, wr_be);
      else if (snap)    mtimeh_shadow <= mtime[63:32];

      if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], lane_wr.data, wr_be);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], lane_wr.data, wr_be);
      if (wr_ctrl)   ctrl            <= merge_bytes(ctrl, lane_wr.data, wr_be) & CTRL_MASK;

      timer_irq <= ctrl[CTRL_IE_BIT] && (mtime >= mtimecmp);
    end
  end

  always_comb begin
    rd_word = 32'h0;
    case (reg_idx)
      IDX_MTIME_LO: rd_word = mtime[31:0];
      IDX_MTIME_HI: rd_word = mtimeh_shadow;
      IDX_CMP_LO:   rd_word = mtimecmp[31:0];
      IDX_CMP_HI:   rd_word = mtimecmp[63:32];
      IDX_CTRL:     rd_word = ctrl;
      default:      rd_word = 32'h0;
    endcase
  end

  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_data = 32'h0;
    if (aligned) begin
      case (size)
        SIZE_B:  rd_data = RW_type[ZEXT_BIT] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        SIZE_H:  rd_data = RW_type[ZEXT_BIT] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        SIZE_W:  rd_data = rd_word;
        default: rd_data = 32'h0;
      endcase
    end
  end

  assign dout = (R_en && hit) ? rd_data : 32'h0;

endmodule
